// File: rtl/noc_pkg.sv
// Shared types and constants for the router output-link arbiter.
// The optional NOC_ARB_STATS_EN build uses cnt_t for its per-input accept counters.
package noc_pkg;

    localparam int PKT_W     = 11;
    localparam int DEST_LSB  = 1;
    localparam int DEST_MSB  = 3;
    localparam int NUM_RL_CH = 3;
    localparam int CNT_W     = 16;

    typedef logic [PKT_W-1:0] pkt_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        ARB_EMPTY,
        ARB_FULL
    } arb_state_e;

    // First input to consider after `last` was served; an out-of-range `last` falls back to input 0.
    function automatic logic [1:0] rr_next(input logic [1:0] last);
        return (last >= 2'd2) ? 2'd0 : last + 2'd1;
    endfunction

    function automatic logic [DEST_MSB-DEST_LSB:0] pkt_dest(input pkt_t pkt);
        return pkt[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/noc_out_arbiter_if.sv
// Handshake bundle between the three RL channels, the link arbiter and the downstream consumer.
// master = requesters plus downstream; slave = the arbiter.
interface noc_out_arbiter_if;
    import noc_pkg::*;

    logic [NUM_RL_CH-1:0] in_valid;
    logic [NUM_RL_CH-1:0] in_ready;
    pkt_t [NUM_RL_CH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    pkt_t                 out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/noc_out_arbiter_rr_pick.sv
// Purely combinational three-way round-robin picker: one-hot grant plus encoded index,
// scanning upward from the input after `last_i` with wrap 2->0.
module rr_pick
    import noc_pkg::*;
(
    input  logic [NUM_RL_CH-1:0] req_i,
    input  logic [1:0]           last_i,
    output logic [NUM_RL_CH-1:0] gnt_o,
    output logic [1:0]           idx_o
);

    logic [1:0] start;
    logic [2:0] pos;
    logic       found;

    // NOTE: every output and temporary gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        start = rr_next(last_i);
        for (int k = 0; k < NUM_RL_CH; k++) begin
            pos = {1'b0, start} + 3'(k);
            if (pos >= 3'd3) begin
                pos = pos - 3'd3;
            end
            if (!found && req_i[pos[1:0]]) begin
                found             = 1'b1;
                gnt_o[pos[1:0]]   = 1'b1;
                idx_o             = pos[1:0];
            end
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Round-robin arbiter sharing one router output link among three RL channels, with a single
// registered output slot. Optional per-input accept counters under `define NOC_ARB_STATS_EN.
module noc_out_arbiter
    import noc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    noc_out_arbiter_if.slave        link
`ifdef NOC_ARB_STATS_EN
    ,
    output cnt_t [NUM_RL_CH-1:0]    grant_cnt_o
`endif
);

    arb_state_e           state_q;
    pkt_t                 data_q;
    logic [1:0]           last_q;

    logic                 load_en;
    logic                 accept;
    logic [NUM_RL_CH-1:0] gnt;
    logic [1:0]           gnt_idx;

    rr_pick u_rr_pick (
        .req_i  (link.in_valid),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    // The slot can take a packet when empty or when it is draining this cycle; no grant while in reset.
    assign load_en       = (state_q == ARB_EMPTY) || link.out_ready;
    assign link.in_ready = (load_en && rst_n) ? gnt : '0;
    assign accept        = |link.in_ready;

    assign link.out_valid = (state_q == ARB_FULL);
    assign link.out_data  = data_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_EMPTY;
            data_q  <= '0;
            last_q  <= 2'd2;
        end else begin
            if (accept) begin
                data_q <= link.in_data[gnt_idx];
                last_q <= gnt_idx;
            end
            case (state_q)
                ARB_EMPTY: if (accept) state_q <= ARB_FULL;
                ARB_FULL:  if (link.out_ready && !accept) state_q <= ARB_EMPTY;
                default:   state_q <= ARB_EMPTY;
            endcase
        end
    end

`ifdef NOC_ARB_STATS_EN
    cnt_t [NUM_RL_CH-1:0] grant_cnt_q;
    cnt_t [NUM_RL_CH-1:0] grant_cnt_d;

    // Counters saturate rather than wrap so a long run never reports a small count.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < NUM_RL_CH; i++) begin
            if (link.in_ready[i] && (grant_cnt_q[i] != '1)) begin
                grant_cnt_d[i] = grant_cnt_q[i] + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed self-checking bench for noc_out_arbiter; counter checks only when NOC_ARB_STATS_EN is defined.
module tb_noc_out_arbiter;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    noc_out_arbiter_if bus ();

`ifdef NOC_ARB_STATS_EN
    cnt_t [NUM_RL_CH-1:0] grant_cnt;
`endif

    noc_out_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (bus)
`ifdef NOC_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = '0;
        rst_n        = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    pkt_t       t2_out [3] = '{11'h101, 11'h202, 11'h404};
    logic [2:0] t2_rdy [3] = '{3'b001, 3'b010, 3'b100};
    logic [2:0] t4_vld [7] = '{3'b011, 3'b010, 3'b011, 3'b010, 3'b111, 3'b111, 3'b111};
    logic [2:0] t4_rdy [7] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    pkt_t       t4_out [7] = '{11'h0A0, 11'h0B1, 11'h0A0, 11'h0B1, 11'h0C2, 11'h0A0, 11'h0B1};

    initial begin
        // Reset: outputs cleared and no grant even with all inputs requesting.
        rst_n         = 1'b0;
        bus.in_valid  = 3'b111;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 16'(bus.out_valid), 16'h0);
        check("rst_out_data",  16'(bus.out_data),  16'h0);
        check("rst_in_ready",  16'(bus.in_ready),  16'h0);
        bus.in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request on input 1.
        bus.in_valid   = 3'b010;
        bus.in_data[1] = 11'h2A6;
        bus.out_ready  = 1'b1;
        #1;
        check("t1_in_ready", 16'(bus.in_ready),  16'h2);
        check("t1_pre_valid", 16'(bus.out_valid), 16'h0);
        tick();
        check("t1_out_valid", 16'(bus.out_valid), 16'h1);
        check("t1_out_data",  16'(bus.out_data),  16'h2A6);
        bus.in_valid = '0;
        #1;
        check("t1_idle_ready", 16'(bus.in_ready), 16'h0);
        tick();
        check("t1_drain_valid", 16'(bus.out_valid), 16'h0);

        // All three requesting from reset: 0,1,2,0,1,2 at one packet per cycle.
        do_reset();
        bus.in_data[0] = 11'h101;
        bus.in_data[1] = 11'h202;
        bus.in_data[2] = 11'h404;
        bus.in_valid   = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t2_in_ready", 16'(bus.in_ready), 16'(t2_rdy[k % 3]));
            tick();
            check("t2_out_valid", 16'(bus.out_valid), 16'h1);
            check("t2_out_data",  16'(bus.out_data),  16'(t2_out[k % 3]));
        end

        // Backpressure: hold 3F2 (granted from input 2) for 5 cycles with inputs 0 and 2 waiting.
        bus.in_valid   = 3'b100;
        bus.in_data[2] = 11'h3F2;
        tick();
        check("t3_load_data", 16'(bus.out_data), 16'h3F2);
        bus.out_ready  = 1'b0;
        bus.in_valid   = 3'b101;
        bus.in_data[0] = 11'h011;
        bus.in_data[2] = 11'h455;
        repeat (5) begin
            #1;
            check("t3_bp_in_ready",  16'(bus.in_ready),  16'h0);
            check("t3_bp_out_data",  16'(bus.out_data),  16'h3F2);
            check("t3_bp_out_valid", 16'(bus.out_valid), 16'h1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("t3_resume_ready0", 16'(bus.in_ready), 16'h1);
        tick();
        check("t3_resume_data0", 16'(bus.out_data), 16'h011);
        #1;
        check("t3_resume_ready2", 16'(bus.in_ready), 16'h4);
        tick();
        check("t3_resume_data2", 16'(bus.out_data), 16'h455);
        bus.in_valid = '0;
        tick();
        check("t3_empty_valid", 16'(bus.out_valid), 16'h0);

        // Fairness: input 1 steady, input 0 toggling, then all three.
        bus.in_data[0] = 11'h0A0;
        bus.in_data[1] = 11'h0B1;
        bus.in_data[2] = 11'h0C2;
        for (int k = 0; k < 7; k++) begin
            bus.in_valid = t4_vld[k];
            #1;
            check("t4_in_ready", 16'(bus.in_ready), 16'(t4_rdy[k]));
            tick();
            check("t4_out_data", 16'(bus.out_data), 16'(t4_out[k]));
        end

        // Asynchronous reset while the slot is full and stalled.
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        #1;
        check("t5_pre_valid", 16'(bus.out_valid), 16'h1);
        bus.in_valid = 3'b111;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 16'(bus.out_valid), 16'h0);
        check("t5_rst_data",  16'(bus.out_data),  16'h0);
        check("t5_rst_ready", 16'(bus.in_ready),  16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_first_ready", 16'(bus.in_ready), 16'h1);
        tick();
        check("t5_first_valid", 16'(bus.out_valid), 16'h1);
        check("t5_first_data",  16'(bus.out_data),  16'h0A0);

`ifdef NOC_ARB_STATS_EN
        // Seven accepts on input 2, then saturation from a preloaded 16'hFFFF.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 3'b100;
        repeat (7) tick();
        bus.in_valid = '0;
        #1;
        check("st_cnt2", 16'(grant_cnt[2]), 16'd7);
        check("st_cnt1", 16'(grant_cnt[1]), 16'd0);
        check("st_cnt0", 16'(grant_cnt[0]), 16'd0);
        @(negedge clk);
        force dut.grant_cnt_q = {16'hFFFF, 16'h0000, 16'h0000};
        #1;
        release dut.grant_cnt_q;
        bus.in_valid = 3'b100;
        tick();
        bus.in_valid = '0;
        #1;
        check("st_sat2", 16'(grant_cnt[2]), 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noc_out_arbiter.md
# noc_out_arbiter

Clocked three-input round-robin arbiter that shares one router output link among the three routing-logic channels that can target it (channel1/channel2/channel3 from the neighbouring RL blocks). Each winning 11-bit packet is captured into a single output register and presented downstream with a valid/ready handshake. The arbiter sits between the RL channel outputs and the RL `arbiter_input` port of the same router, and guarantees fair, starvation-free access to the link.

## Interface
- `NUM_IN`, 3: number of requesters. Fixed at 3; other values are unsupported.
- `WIDTH`, 11: packet width. Bit 0 is the flag bit, [3:1] the destination router, [10:4] the payload.
- `clk`  in  1  single clock. All state changes occur on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  3  per-requester packet valid.
- `in_data`  in  3×WIDTH  per-requester packet. Index i corresponds to channel(i+1).
- `in_ready`  out  3  one-hot-or-zero grant/accept. A transfer on input i occurs when `in_valid[i] && in_ready[i]`.
- `out_valid`  out  1  output register holds a packet.
- `out_data`  out  WIDTH  registered packet.
- `out_ready`  in  1  downstream accepts.
- `grant_cnt` (only with `NOC_ARB_STATS_EN`)  out  3×16  per-input accepted-packet counters.

## Operation
- Output register FSM, two states:
  - EMPTY: `out_valid=0`.
  - FULL: `out_valid=1`.
- `load_en = !out_valid || out_ready`. When `load_en` is 0, all `in_ready` are 0.
- When `load_en` is 1 and any `in_valid` is set, exactly one input is granted:
  - The winner is the first valid input at or after `(last_grant+1) mod 3`, scanning upward with wrap 2→0.
  - On the next edge: `out_data` ← winner's data; `out_valid` ← 1; `last_grant` ← winner.
- When `load_en` is 1 and no input is valid:
  - If `out_ready` was high, `out_valid` ← 0.
  - `last_grant` is unchanged.
- FSM transitions:
  - EMPTY→FULL on any accept.
  - FULL→FULL when `out_ready` and an accept occur in the same cycle (back-to-back transfer).
  - FULL→EMPTY when `out_ready` is high and there is no accept.
  - FULL holds while `out_ready` is low.
- Packets pass through bit-for-bit. No field decoding or modification.
- Fairness: a continuously valid input waits at most 2 grants before being served.
- Inputs must hold `in_data` stable while `in_valid && !in_ready`. The arbiter may change its grant choice across cycles while a requester waits.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `last_grant=2` (input 0 has first priority), FSM=EMPTY, `grant_cnt`=0.
- Latency: packet accepted at edge N appears on `out_valid`/`out_data` after edge N, i.e. one cycle.
- Throughput: one packet per cycle while `out_ready` stays high.
- `in_ready` is combinational from `in_valid`, `last_grant`, `out_valid` and `out_ready`. Downstream must not make `out_ready` depend on `in_ready`.
- `out_data` is stable while `out_valid && !out_ready`.
- Simultaneous requests on all three inputs from reset: grant order is 0,1,2,0,...
- Reset asserted mid-transfer: the held packet is dropped and all outputs return to their reset values immediately (asynchronously). No `in_ready` is asserted while `rst_n=0`.

## Configuration
- `NOC_ARB_STATS_EN` defined:
  - `grant_cnt` port exists.
  - Each accept on input i increments `grant_cnt[i]` by 1.
  - Counters saturate at 16'hFFFF and reset to 0.
- `NOC_ARB_STATS_EN` undefined: no counters and no `grant_cnt` port. Arbitration behaviour is identical in both builds.

## Structure
- Shared package `noc_pkg`:
  - `PKT_W=11`, `DEST_LSB=1`, `DEST_MSB=3`, `NUM_RL_CH=3`.
  - `typedef logic [PKT_W-1:0] pkt_t`.
  - FSM enum `arb_state_e {ARB_EMPTY, ARB_FULL}`.
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `req[2:0]`, `last[1:0]`.
  - Outputs: one-hot `gnt[2:0]` and encoded `idx[1:0]`.
  - Reused by the top-level link arbiter.

## Test plan
- Reset then single request: `in_valid=3'b010`, `in_data[1]=11'h2A6`, `out_ready=1` → `in_ready=3'b010` that cycle; next cycle `out_valid=1`, `out_data=11'h2A6`; `out_valid=0` one cycle after `in_valid` drops.
- All three requesting continuously with data 11'h101/11'h202/11'h404 and `out_ready=1` → `out_data` sequence 101,202,404,101,... at one packet per cycle.
- Backpressure: `out_valid=1` holding 11'h3F2 with `out_ready=0` for 5 cycles while inputs 0 and 2 request → `in_ready=0` and `out_data` stays 11'h3F2; after `out_ready` rises, next grant is input 0 if `last_grant=2`.
- Fairness: input 1 requests continuously while input 0 toggles on/off → input 1 is never skipped while the others are idle, and with all three inputs requesting each is served within 3 grants.
- Reset mid-operation: assert `rst_n=0` while `out_valid=1` → `out_valid` and `out_data` go to 0 asynchronously; after release, first grant goes to input 0 when all three inputs request.
- With `NOC_ARB_STATS_EN`: 7 accepts on input 2 → `grant_cnt[2]=7`, others 0; forcing a counter to 16'hFFFF followed by another accept → counter stays 16'hFFFF.
